// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - function codes and class encodings for beta_alu
package alu_pkg;

  // Full 6-bit function codes
  localparam logic [5:0] ALUFN_CMPEQ = 6'b000011;
  localparam logic [5:0] ALUFN_CMPLT = 6'b000101;
  localparam logic [5:0] ALUFN_CMPLE = 6'b000111;
  localparam logic [5:0] ALUFN_ADD   = 6'b010000;
  localparam logic [5:0] ALUFN_SUB   = 6'b010001;
  localparam logic [5:0] ALUFN_MUL   = 6'b010010;
  localparam logic [5:0] ALUFN_AND   = 6'b101000;
  localparam logic [5:0] ALUFN_OR    = 6'b101110;
  localparam logic [5:0] ALUFN_XOR   = 6'b100110;
  localparam logic [5:0] ALUFN_XNOR  = 6'b101001;
  localparam logic [5:0] ALUFN_SHL   = 6'b110000;
  localparam logic [5:0] ALUFN_SHR   = 6'b110001;
  localparam logic [5:0] ALUFN_SRA   = 6'b110011;

  // Operation class carried in ALUFN[5:4]
  localparam logic [1:0] CLS_CMP   = 2'b00;
  localparam logic [1:0] CLS_ARITH = 2'b01;
  localparam logic [1:0] CLS_BOOL  = 2'b10;
  localparam logic [1:0] CLS_SHIFT = 2'b11;

endpackage

// File: rtl/alu_shifter.sv
// rtl/alu_shifter.sv - combinational barrel shifter (left, logical right, arithmetic right)
module alu_shifter #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   amount,
  input  logic             dir,     // 0 = left, 1 = right
  input  logic             arith,   // right shifts only: replicate sign bit
  output logic [WIDTH-1:0] result
);

  // Select the shift flavour; amount 0 naturally passes a through
  always_comb begin
    result = a << amount;
    if (dir) begin
      if (arith) result = $unsigned($signed(a) >>> amount);
      else       result = a >> amount;
    end
  end

endmodule

// File: rtl/beta_alu.sv
// rtl/beta_alu.sv - registered 32-bit Beta ALU; optional multiplier under ALU_MUL_EN
module beta_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       ALUFN,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Y
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] bool_res;
  logic [WIDTH-1:0] shift_res;
  logic [WIDTH-1:0] y_next;
  logic             eq;
  logic             n_flag;
  logic             v_flag;
  logic             lt;

  assign sum  = A + B;
  assign diff = A - B;
  assign eq   = (A == B);

  // Signed less-than from the subtractor: negative result xor overflow
  assign n_flag = diff[WIDTH-1];
  assign v_flag = (A[WIDTH-1] ^ B[WIDTH-1]) & (diff[WIDTH-1] ^ A[WIDTH-1]);
  assign lt     = n_flag ^ v_flag;

  // Each result bit is a lookup into ALUFN[3:0] indexed by {A[i],B[i]}
  always_comb begin
    bool_res = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bool_res[i] = ALUFN[{A[i], B[i]}];
    end
  end

  // ALUFN[0] picks right vs left, ALUFN[1] picks sign fill
  alu_shifter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_shifter (
    .a      (A),
    .amount (B[SHW-1:0]),
    .dir    (ALUFN[0]),
    .arith  (ALUFN[1]),
    .result (shift_res)
  );

  // Result mux: only listed codes produce a value, everything else yields zero
  always_comb begin
    y_next = '0;
    case (ALUFN)
      ALUFN_CMPEQ: y_next = {{(WIDTH-1){1'b0}}, eq};
      ALUFN_CMPLT: y_next = {{(WIDTH-1){1'b0}}, lt};
      ALUFN_CMPLE: y_next = {{(WIDTH-1){1'b0}}, lt | eq};
      ALUFN_ADD:   y_next = sum;
      ALUFN_SUB:   y_next = diff;
`ifdef ALU_MUL_EN
      ALUFN_MUL:   y_next = A * B;
`endif
      ALUFN_SHL,
      ALUFN_SHR,
      ALUFN_SRA:   y_next = shift_res;
      default: begin
        if (ALUFN[5:4] == CLS_BOOL) y_next = bool_res;
      end
    endcase
  end

  // Single output register; cleared asynchronously and held at zero during reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) Y <= '0;
    else        Y <= y_next;
  end

endmodule

// File: tb/tb_beta_alu.sv
// tb/tb_beta_alu.sv - self-checking bench for beta_alu against a behavioural model
module tb_beta_alu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [5:0]   alufn;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] y;
  logic [W-1:0] exp_y;
  bit           cmp_on = 1'b0;
  int           checks = 0;
  int           errors = 0;

  logic [5:0] codes [13] = '{6'b000011, 6'b000101, 6'b000111, 6'b010000, 6'b010001,
                             6'b010010, 6'b101000, 6'b101110, 6'b100110, 6'b101001,
                             6'b110000, 6'b110001, 6'b110011};

  always #5 clk = ~clk;

  beta_alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ALUFN (alufn),
    .A     (a),
    .B     (b),
    .Y     (y)
  );

  function automatic logic [W-1:0] model(input logic [5:0] fn, input logic [W-1:0] x,
                                          input logic [W-1:0] z);
    int amt;
    amt = int'(z[4:0]);
    case (fn)
      6'b000011: return (x == z) ? 32'd1 : 32'd0;
      6'b000101: return ($signed(x) < $signed(z)) ? 32'd1 : 32'd0;
      6'b000111: return ($signed(x) <= $signed(z)) ? 32'd1 : 32'd0;
      6'b010000: return x + z;
      6'b010001: return x - z;
`ifdef ALU_MUL_EN
      6'b010010: return x * z;
`endif
      6'b110000: return x << amt;
      6'b110001: return x >> amt;
      6'b110011: return $unsigned($signed(x) >>> amt);
      default: begin
        if (fn[5:4] == 2'b10)
          return ({W{fn[0]}} & ~x & ~z) | ({W{fn[1]}} & ~x & z) |
                 ({W{fn[2]}} &  x & ~z) | ({W{fn[3]}} &  x & z);
        return '0;
      end
    endcase
  endfunction

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, expv);
    end
  endtask

  // Expected output tracks the DUT's sampling: cleared by reset, else f(inputs at the edge)
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_y <= '0;
    else        exp_y <= model(alufn, a, b);
  end

  // Compare every cycle once checking is enabled
  always @(negedge clk) begin
    if (cmp_on) check("model_cmp", y, exp_y);
  end

  // Called at a negedge: apply inputs, wait one cycle, check the hand-computed value
  task automatic op(input string nm, input logic [5:0] fn, input logic [W-1:0] x,
                    input logic [W-1:0] z, input logic [W-1:0] expv);
    alufn = fn;
    a     = x;
    b     = z;
    @(negedge clk);
    check(nm, y, expv);
  endtask

  initial begin
    rst_n = 1'b0;
    alufn = 6'b010000;
    a     = 32'd5;
    b     = 32'd6;
    repeat (3) @(negedge clk);
    check("reset_y", y, 32'd0);
    rst_n  = 1'b1;
    cmp_on = 1'b1;

    check("model_cmplt_neg", model(6'b000101, 32'hFFFFFFFF, 32'd1), 32'd1);
    check("model_xnor", model(6'b101001, 32'd15, 32'd13), 32'hFFFFFFFD);
    check("model_sra", model(6'b110011, 32'hFFFFFFF0, 32'd4), 32'hFFFFFFFF);

    op("cmpeq_15_13", 6'b000011, 32'd15, 32'd13, 32'd0);
    op("cmplt_15_13", 6'b000101, 32'd15, 32'd13, 32'd0);
    op("cmple_15_13", 6'b000111, 32'd15, 32'd13, 32'd0);
    op("cmpeq_13_13", 6'b000011, 32'd13, 32'd13, 32'd1);
    op("cmplt_13_13", 6'b000101, 32'd13, 32'd13, 32'd0);
    op("cmple_13_13", 6'b000111, 32'd13, 32'd13, 32'd1);
    op("cmpeq_13_15", 6'b000011, 32'd13, 32'd15, 32'd0);
    op("cmplt_13_15", 6'b000101, 32'd13, 32'd15, 32'd1);
    op("cmple_13_15", 6'b000111, 32'd13, 32'd15, 32'd1);
    op("cmplt_m1_1", 6'b000101, 32'hFFFFFFFF, 32'd1, 32'd1);
    op("cmplt_max_min", 6'b000101, 32'h7FFFFFFF, 32'h80000000, 32'd0);
    op("add_15_13", 6'b010000, 32'd15, 32'd13, 32'd28);
    op("add_wrap", 6'b010000, 32'hFFFFFFFF, 32'd1, 32'd0);
    op("sub_15_13", 6'b010001, 32'd15, 32'd13, 32'd2);
    op("sub_13_13", 6'b010001, 32'd13, 32'd13, 32'd0);
    op("sub_13_15", 6'b010001, 32'd13, 32'd15, 32'hFFFFFFFE);
    op("and", 6'b101000, 32'd15, 32'd13, 32'd13);
    op("or", 6'b101110, 32'd15, 32'd13, 32'd15);
    op("xor", 6'b100110, 32'd15, 32'd13, 32'd2);
    op("xnor", 6'b101001, 32'd15, 32'd13, 32'hFFFFFFFD);
    op("shl_15_4", 6'b110000, 32'd15, 32'd4, 32'd240);
    op("shr_15_4", 6'b110001, 32'd15, 32'd4, 32'd0);
    op("sra_m16_4", 6'b110011, 32'hFFFFFFF0, 32'd4, 32'hFFFFFFFF);
    op("shr_msb_31", 6'b110001, 32'h80000000, 32'd31, 32'd1);
    op("shl_15_36", 6'b110000, 32'd15, 32'd36, 32'd240);
    op("shl_amt0", 6'b110000, 32'h12345678, 32'd0, 32'h12345678);
    op("code_110010", 6'b110010, 32'd15, 32'd4, 32'd0);
`ifdef ALU_MUL_EN
    op("mul_6_7", 6'b010010, 32'd6, 32'd7, 32'd42);
`else
    op("mul_6_7", 6'b010010, 32'd6, 32'd7, 32'd0);
`endif
    op("code_000000", 6'b000000, 32'd6, 32'd7, 32'd0);

    // Asynchronous reset while Y holds a nonzero value
    op("add_pre_rst", 6'b010000, 32'd15, 32'd13, 32'd28);
    #2 rst_n = 1'b0;
    #1 check("async_rst", y, 32'd0);
    @(negedge clk);
    check("rst_hold", y, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    op("cmpeq_after_rst", 6'b000011, 32'd13, 32'd13, 32'd1);

    // Back-to-back random operations, checked by the per-cycle compare process
    repeat (600) begin
      int sel;
      alufn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : codes[$urandom_range(0, 12)];
      sel = $urandom_range(0, 3);
      case (sel)
        0: begin a = $urandom; b = $urandom; end
        1: begin a = $urandom_range(0, 40); b = $urandom_range(0, 40); end
        2: begin a = $urandom; b = a; end
        default: begin
          a = ($urandom_range(0, 1) == 1) ? 32'h80000000 : 32'h7FFFFFFF;
          b = ($urandom_range(0, 1) == 1) ? 32'hFFFFFFFF : $urandom;
        end
      endcase
      @(negedge clk);
    end

    cmp_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
